// File: rtl/tetris_piece_ctrl.sv
// Active falling-piece sequencer: spawn, MCU commands, gravity, collision
// handshake with an external checker, and lock hand-off to the board writer.
module tetris_piece_ctrl #(
  parameter int SPAWN_X = 4,
  parameter int SPAWN_Y = 0,
  parameter int LINES_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               gravity_tick,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd,
  output logic               cmd_ready,
  input  logic [2:0]         next_type,
  output logic               next_take,
  output logic               chk_req,
  output logic [13:0]        chk_piece,
  input  logic               chk_done,
  input  logic               chk_ok,
  output logic               lock_req,
  input  logic               lock_ack,
  input  logic [2:0]         lock_lines,
  output logic [13:0]        active_piece,
  output logic               piece_valid,
  output logic               game_over,
  output logic [LINES_W-1:0] lines_total
);

  typedef struct packed {
    logic [2:0] ptype;
    logic [1:0] rot;
    logic [3:0] x;
    logic [4:0] y;
  } active_piece_t;

  typedef enum logic [1:0] {ROTATE = 2'd0, SOFT_DROP = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} cmd_t;

  typedef enum logic [2:0] {
    IDLE, SPAWN, SPAWN_CHK, READY, MOVE_CHK, LOCK, GAME_OVER
  } state_t;

  state_t               state_q, state_d;
  active_piece_t        piece_q, piece_d;
  active_piece_t        cand_q, cand_d;
  logic                 drop_q, drop_d;     // in-flight move locks on rejection
  logic                 pend_q, pend_d;
  logic                 valid_q, valid_d;
  logic [LINES_W-1:0]   lines_q, lines_d;
  logic [LINES_W:0]     lines_sum;
  logic [LINES_W-1:0]   lines_sat;

  assign lines_sum = {1'b0, lines_q} + {{(LINES_W-2){1'b0}}, lock_lines};
  assign lines_sat = lines_sum[LINES_W] ? '1 : lines_sum[LINES_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      piece_q <= '0;
      cand_q  <= '0;
      drop_q  <= 1'b0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      lines_q <= '0;
    end else begin
      state_q <= state_d;
      piece_q <= piece_d;
      cand_q  <= cand_d;
      drop_q  <= drop_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      lines_q <= lines_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    piece_d   = piece_q;
    cand_d    = cand_q;
    drop_d    = drop_q;
    pend_d    = pend_q;
    valid_d   = valid_q;
    lines_d   = lines_q;
    cmd_ready = 1'b0;
    next_take = 1'b0;
    chk_req   = 1'b0;
    lock_req  = 1'b0;
    game_over = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          lines_d = '0;
          state_d = SPAWN;
        end
      end
      SPAWN: begin
        next_take = 1'b1;
        cand_d    = '{ptype: next_type, rot: 2'd0, x: 4'(SPAWN_X), y: 5'(SPAWN_Y)};
        state_d   = SPAWN_CHK;
      end
      SPAWN_CHK: begin
        chk_req = 1'b1;
        if (chk_done) begin
          if (chk_ok) begin
            piece_d = cand_q;
            valid_d = 1'b1;
            state_d = READY;
          end else begin
            valid_d = 1'b0;
            state_d = GAME_OVER;
          end
        end
      end
      READY: begin
        // Gravity preempts commands; a pending command simply waits.
        if (pend_q || gravity_tick) begin
          cand_d   = piece_q;
          cand_d.y = piece_q.y + 5'd1;
          drop_d   = 1'b1;
          pend_d   = 1'b0;
          state_d  = MOVE_CHK;
        end else begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            cand_d = piece_q;
            drop_d = 1'b0;
            case (cmd_t'(cmd))
              LEFT:      cand_d.x   = piece_q.x - 4'd1;
              RIGHT:     cand_d.x   = piece_q.x + 4'd1;
              ROTATE:    cand_d.rot = piece_q.rot + 2'd1;
              SOFT_DROP: begin
                cand_d.y = piece_q.y + 5'd1;
                drop_d   = 1'b1;
              end
            endcase
            state_d = MOVE_CHK;
          end
        end
      end
      MOVE_CHK: begin
        chk_req = 1'b1;
        if (chk_done) begin
          if (chk_ok) begin
            piece_d = cand_q;
            state_d = READY;
          end else begin
            state_d = drop_q ? LOCK : READY;
          end
        end
      end
      LOCK: begin
        lock_req = 1'b1;
        if (lock_ack) begin
          lines_d = lines_sat;
          valid_d = 1'b0;
          state_d = SPAWN;
        end
      end
      GAME_OVER: begin
        game_over = 1'b1;
        if (start) begin
          lines_d = '0;
          state_d = SPAWN;
        end
      end
      default: state_d = IDLE;
    endcase

    if (gravity_tick && !(state_q inside {READY, IDLE, GAME_OVER}))
      pend_d = 1'b1;
    // A fresh piece never inherits descent requested for the previous one.
    if (state_d == SPAWN && state_q != SPAWN)
      pend_d = 1'b0;
  end

  assign chk_piece    = cand_q;
  assign active_piece = piece_q;
  assign piece_valid  = valid_q;
  assign lines_total  = lines_q;

endmodule

// File: tb/tb_tetris_piece_ctrl.sv
// Directed bench for tetris_piece_ctrl; the collision checker and board
// writer are played by hand from a single stimulus sequence.
module tb_tetris_piece_ctrl;

  localparam logic [1:0] C_ROT = 2'd0, C_DROP = 2'd1, C_LEFT = 2'd2, C_RIGHT = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        gravity_tick = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = 2'd0;
  logic        cmd_ready;
  logic [2:0]  next_type = 3'd0;
  logic        next_take;
  logic        chk_req;
  logic [13:0] chk_piece;
  logic        chk_done = 1'b0;
  logic        chk_ok = 1'b0;
  logic        lock_req;
  logic        lock_ack = 1'b0;
  logic [2:0]  lock_lines = 3'd0;
  logic [13:0] active_piece;
  logic        piece_valid;
  logic        game_over;
  logic [15:0] lines_total;

  int tests = 0;
  int fails = 0;

  tetris_piece_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .gravity_tick(gravity_tick),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .next_type(next_type), .next_take(next_take),
    .chk_req(chk_req), .chk_piece(chk_piece), .chk_done(chk_done), .chk_ok(chk_ok),
    .lock_req(lock_req), .lock_ack(lock_ack), .lock_lines(lock_lines),
    .active_piece(active_piece), .piece_valid(piece_valid),
    .game_over(game_over), .lines_total(lines_total)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] pc(input int t, input int r, input int x, input int y);
    return {3'(t), 2'(r), 4'(x), 5'(y)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plays the collision checker: waits for chk_req then strobes one response.
  task automatic respond(input logic ok);
    int n = 0;
    while (!chk_req && n < 20) begin @(negedge clk); n++; end
    check("chk_req_seen", {31'd0, chk_req}, 32'd1);
    chk_done = 1'b1; chk_ok = ok;
    @(negedge clk);
    chk_done = 1'b0; chk_ok = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] c, input logic ok);
    int n = 0;
    cmd_valid = 1'b1; cmd = c;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    check("cmd_ready_seen", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    respond(ok);
  endtask

  task automatic do_lock(input logic [2:0] lines);
    lock_ack = 1'b1; lock_lines = lines;
    @(negedge clk);
    lock_ack = 1'b0; lock_lines = 3'd0;
  endtask

  initial begin
    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_active", 32'(active_piece), 32'd0);
    check("rst_valid", {31'd0, piece_valid}, 32'd0);
    check("rst_lines", 32'(lines_total), 32'd0);
    check("rst_reqs", {29'd0, chk_req, lock_req, cmd_ready}, 32'd0);
    reset = 1'b0;

    // Spawn a T piece (type 2)
    @(negedge clk);
    start = 1'b1; next_type = 3'd2;
    @(negedge clk);
    start = 1'b0;
    check("spawn_take", {31'd0, next_take}, 32'd1);
    @(negedge clk);
    check("spawn_take_pulse", {31'd0, next_take}, 32'd0);
    check("spawn_cand", 32'(chk_piece), 32'(pc(2, 0, 4, 0)));
    respond(1'b1);
    check("spawn_active", 32'(active_piece), 32'(pc(2, 0, 4, 0)));
    check("spawn_valid", {31'd0, piece_valid}, 32'd1);
    check("spawn_ready", {31'd0, cmd_ready}, 32'd1);
    check("spawn_chk_drop", {31'd0, chk_req}, 32'd0);

    // Moves and rotations
    send_cmd(C_LEFT, 1'b1);
    check("left_x", 32'(active_piece), 32'(pc(2, 0, 3, 0)));
    send_cmd(C_RIGHT, 1'b1);
    send_cmd(C_RIGHT, 1'b1);
    for (int i = 0; i < 5; i++) send_cmd(C_ROT, 1'b1);
    check("cmds_result", 32'(active_piece), 32'(pc(2, 1, 5, 0)));

    // Rejected lateral move leaves piece unchanged
    send_cmd(C_LEFT, 1'b0);
    check("rej_left", 32'(active_piece), 32'(pc(2, 1, 5, 0)));
    check("rej_left_ready", {31'd0, cmd_ready}, 32'd1);

    // Gravity and command in the same READY cycle
    gravity_tick = 1'b1; cmd_valid = 1'b1; cmd = C_LEFT;
    #1 check("grav_prio_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check("grav_cand", 32'(chk_piece), 32'(pc(2, 1, 5, 1)));
    check("busy_ready", {31'd0, cmd_ready}, 32'd0);
    // Three ticks while busy collapse into one pending descent
    @(negedge clk); @(negedge clk); @(negedge clk);
    gravity_tick = 1'b0;
    respond(1'b1);
    check("grav_commit", 32'(active_piece), 32'(pc(2, 1, 5, 1)));
    check("pend_blocks_cmd", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check("pend_cand", 32'(chk_piece), 32'(pc(2, 1, 5, 2)));
    respond(1'b1);
    check("pend_commit", 32'(active_piece), 32'(pc(2, 1, 5, 2)));
    check("cmd_after_grav", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("left_cand", 32'(chk_piece), 32'(pc(2, 1, 4, 2)));
    respond(1'b1);
    check("left_commit", 32'(active_piece), 32'(pc(2, 1, 4, 2)));
    check("single_extra", {30'd0, chk_req, cmd_ready}, 32'd1);

    // Rejected soft drop locks the piece
    send_cmd(C_DROP, 1'b0);
    check("lock_req", {31'd0, lock_req}, 32'd1);
    check("lock_valid", {31'd0, piece_valid}, 32'd1);
    @(negedge clk);
    check("lock_held", {31'd0, lock_req}, 32'd1);
    do_lock(3'd2);
    check("lines_2", 32'(lines_total), 32'd2);
    check("respawn_take", {31'd0, next_take}, 32'd1);
    check("respawn_invalid", {31'd0, piece_valid}, 32'd0);
    check("lock_released", {31'd0, lock_req}, 32'd0);

    // Spawn blocked -> game over
    @(negedge clk);
    respond(1'b0);
    check("go_flag", {31'd0, game_over}, 32'd1);
    check("go_valid", {31'd0, piece_valid}, 32'd0);
    check("go_ready", {31'd0, cmd_ready}, 32'd0);

    // Restart from game over
    start = 1'b1; next_type = 3'd6;
    @(negedge clk);
    start = 1'b0;
    check("restart_lines", 32'(lines_total), 32'd0);
    check("restart_take", {31'd0, next_take}, 32'd1);
    @(negedge clk);
    respond(1'b1);
    check("restart_active", 32'(active_piece), 32'(pc(6, 0, 4, 0)));
    send_cmd(C_DROP, 1'b0);
    do_lock(3'd3);
    check("lines_3", 32'(lines_total), 32'd3);
    @(negedge clk);
    respond(1'b1);
    send_cmd(C_DROP, 1'b0);
    check("lock_before_rst", {31'd0, lock_req}, 32'd1);

    // Asynchronous reset mid-lock, between clock edges
    #2 reset = 1'b1;
    #1;
    check("arst_lock", {31'd0, lock_req}, 32'd0);
    check("arst_valid", {31'd0, piece_valid}, 32'd0);
    check("arst_lines", 32'(lines_total), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_rst", {28'd0, next_take, chk_req, game_over, cmd_ready}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
